// File: rtl/sw_dbnc_pkg.sv
// Shared constants for the switch debouncer: FSM encoding, default settle
// window and glitch counter ceiling.
package sw_dbnc_pkg;

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_SETTLING = 1'b1;

    localparam int DBNC_50MHZ_20MS = 1000000;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == GLITCH_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sw_debounce_sync_sync2.sv
// Two-flop synchroniser, parameterised width, async active-high reset to 0.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronise and debounce {en_in, sw_in} as one vector for the encoder.
// Optional glitch counter port enabled by SW_DBNC_GLITCH_CNT_EN.
module sw_debounce_sync
    import sw_dbnc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = DBNC_50MHZ_20MS,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] x_out,
    output logic             en_out,
    output logic             chg,
    output logic             busy
`ifdef SW_DBNC_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    localparam int VW = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [VW-1:0]    w_v;
    logic [VW-1:0]    w_s2;
    logic             w_restart;

    logic [VW-1:0]    r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_state;
    logic [VW-1:0]    r_out;
    logic             r_chg;

    assign w_v = {en_in, sw_in};

    sync2 #(
        .W (VW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (w_v),
        .q   (w_s2)
    );

    // A bounce restarts the window and outranks completion.
    assign w_restart = (r_state == ST_SETTLING) && (w_s2 != r_cand);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand  <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s2 != r_out) begin
                        r_cand  <= w_s2;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLING;
                    end
                end
                ST_SETTLING: begin
                    if (w_restart) begin
                        r_cand <= w_s2;
                        r_cnt  <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_out   <= r_cand;
                        r_chg   <= (r_cand != r_out);
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SW_DBNC_GLITCH_CNT_EN
    logic [7:0] r_glitch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch <= 8'd0;
        end else if (w_restart) begin
            r_glitch <= sat_inc8(r_glitch);
        end
    end

    assign glitch_cnt = r_glitch;
`endif

    assign {en_out, x_out} = r_out;
    assign chg  = r_chg;
    assign busy = (r_state == ST_SETTLING);

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync (STABLE_CYCLES = 4 and = 1 instances).
module tb_sw_debounce_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_in, sw1;
    logic       en_in, en1;
    logic [7:0] x_out, x1;
    logic       en_out, en1_out;
    logic       chg, chg1;
    logic       busy, busy1;
`ifdef SW_DBNC_GLITCH_CNT_EN
    logic [7:0] glitch_cnt, glitch1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sw_debounce_sync #(
        .WIDTH(8), .STABLE_CYCLES(4), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .en_in(en_in),
        .x_out(x_out), .en_out(en_out), .chg(chg), .busy(busy)
`ifdef SW_DBNC_GLITCH_CNT_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    sw_debounce_sync #(
        .WIDTH(8), .STABLE_CYCLES(1), .CNT_W(20)
    ) dut1 (
        .clk(clk), .rst(rst), .sw_in(sw1), .en_in(en1),
        .x_out(x1), .en_out(en1_out), .chg(chg1), .busy(busy1)
`ifdef SW_DBNC_GLITCH_CNT_EN
        , .glitch_cnt(glitch1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_in = 8'h00; en_in = 1'b0; sw1 = 8'h00; en1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_checks++;
            if ({en_out, x_out, chg, busy} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_idle e=%0d got en=%b x=%h chg=%b busy=%b want all 0",
                         e, en_out, x_out, chg, busy);
            end
            n_checks++;
            if ({en1_out, x1, chg1, busy1} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_idle1 e=%0d got en=%b x=%h chg=%b busy=%b want all 0",
                         e, en1_out, x1, chg1, busy1);
            end
        end
`ifdef SW_DBNC_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_glitch got %0d want 0", glitch_cnt);
        end
`endif
    endtask

    task automatic test_bounce_back();
        logic ex_busy;
        for (int e = 1; e <= 10; e++) begin
            sw_in = (e == 1) ? 8'h80 : 8'h00;
            tick();
            ex_busy = (e >= 3) && (e <= 7);
            n_checks++;
            if (busy !== ex_busy || x_out !== 8'h00 || chg !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_back e=%0d got busy=%b x=%h chg=%b want busy=%b x=00 chg=0",
                         e, busy, x_out, chg, ex_busy);
            end
        end
`ifdef SW_DBNC_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL bounce_back_glitch got %0d want 1", glitch_cnt);
        end
`endif
    endtask

    task automatic test_clean_step();
        logic       ex_busy, ex_en, ex_chg;
        logic [7:0] ex_x;
        sw_in = 8'h40; en_in = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            ex_busy = (e >= 3) && (e <= 6);
            ex_x    = (e >= 7) ? 8'h40 : 8'h00;
            ex_en   = (e >= 7);
            ex_chg  = (e == 7);
            n_checks++;
            if (busy !== ex_busy || x_out !== ex_x || en_out !== ex_en || chg !== ex_chg) begin
                n_fail++;
                $display("FAIL clean_step e=%0d got busy=%b x=%h en=%b chg=%b want %b %h %b %b",
                         e, busy, x_out, en_out, chg, ex_busy, ex_x, ex_en, ex_chg);
            end
        end
    endtask

    task automatic test_bounce();
        logic       ex_busy, ex_chg;
        logic [7:0] ex_x;
        int         n_chg = 0;
        for (int e = 1; e <= 18; e++) begin
            if (e >= 9) sw_in = 8'h01;
            else        sw_in = (((e - 1) / 2) % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            if (chg) n_chg++;
            ex_busy = (e >= 3) && (e <= 14);
            ex_x    = (e >= 15) ? 8'h01 : 8'h40;
            ex_chg  = (e == 15);
            n_checks++;
            if (busy !== ex_busy || x_out !== ex_x || en_out !== 1'b1 || chg !== ex_chg) begin
                n_fail++;
                $display("FAIL bounce e=%0d got busy=%b x=%h en=%b chg=%b want %b %h 1 %b",
                         e, busy, x_out, en_out, chg, ex_busy, ex_x, ex_chg);
            end
        end
        n_checks++;
        if (n_chg != 1) begin
            n_fail++;
            $display("FAIL bounce_chg_count got %0d want 1", n_chg);
        end
`ifdef SW_DBNC_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL bounce_glitch got %0d want 5", glitch_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_settle();
        logic       ex_busy, ex_v, ex_chg;
        logic [7:0] ex_x;
        sw_in = 8'hFF;
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_settle_busy got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({en_out, x_out, chg, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset got en=%b x=%h chg=%b busy=%b want all 0",
                     en_out, x_out, chg, busy);
        end
`ifdef SW_DBNC_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_glitch got %0d want 0", glitch_cnt);
        end
`endif
        repeat (2) tick();
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            ex_busy = (e >= 3) && (e <= 6);
            ex_v    = (e >= 7);
            ex_x    = ex_v ? 8'hFF : 8'h00;
            ex_chg  = (e == 7);
            n_checks++;
            if (busy !== ex_busy || x_out !== ex_x || en_out !== ex_v || chg !== ex_chg) begin
                n_fail++;
                $display("FAIL post_reset e=%0d got busy=%b x=%h en=%b chg=%b want %b %h %b %b",
                         e, busy, x_out, en_out, chg, ex_busy, ex_x, ex_v, ex_chg);
            end
        end
    endtask

    task automatic test_stable1();
        logic       ex_busy, ex_chg;
        logic [7:0] ex_x;
        sw1 = 8'h03;
        for (int e = 1; e <= 6; e++) begin
            tick();
            ex_busy = (e == 3);
            ex_x    = (e >= 4) ? 8'h03 : 8'h00;
            ex_chg  = (e == 4);
            n_checks++;
            if (busy1 !== ex_busy || x1 !== ex_x || chg1 !== ex_chg || en1_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stable1 e=%0d got busy=%b x=%h chg=%b en=%b want %b %h %b 0",
                         e, busy1, x1, chg1, en1_out, ex_busy, ex_x, ex_chg);
            end
        end
    endtask

`ifdef SW_DBNC_GLITCH_CNT_EN
    task automatic test_glitch_sat();
        for (int i = 0; i < 320; i++) begin
            sw_in = (i % 2 == 0) ? 8'h00 : 8'hFF;
            tick();
        end
        sw_in = 8'hFF;
        repeat (10) tick();
        n_checks++;
        if (glitch_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL glitch_sat got %0d want 255", glitch_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce_back();
        test_clean_step();
        test_bounce();
        test_reset_mid_settle();
        test_stable1();
`ifdef SW_DBNC_GLITCH_CNT_EN
        test_glitch_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
- Input conditioner placed directly upstream of the 8-to-3 priority encoder / seven-segment stage on the lab board.
- Each cycle it synchronises the raw slide switches (x vector) and the enable switch to clk, then debounces them as one vector.
- It presents a clean, glitch-free `x_out`/`en_out` pair to the encoder, plus a one-cycle change strobe.

Parameters:
- WIDTH, 8, data switch count (x vector width).
- STABLE_CYCLES, 1000000, consecutive clk cycles the synchronised vector must hold before acceptance (20 ms at 50 MHz). Legal range is 1 to 2^CNT_W-1.
- CNT_W, 20, settle counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sw_in  input  WIDTH  raw data switches, asynchronous to clk.
- en_in  input  1  raw enable switch, asynchronous to clk.
- x_out  output  WIDTH  debounced data vector, feeds the encoder x.
- en_out  output  1  debounced enable, feeds the encoder en.
- chg  output  1  one-cycle pulse when {en_out, x_out} takes a new value.
- busy  output  1  high while in SETTLING.

Behaviour:
- Internal vector v = {en_in, sw_in}, width WIDTH+1, handled as a single unit.
- Synchroniser: two flops per bit, reset to 0. s2 = v delayed by two clk edges.
- Registers:
  - cand: candidate vector.
  - cnt: CNT_W bits.
  - state: IDLE or SETTLING.
  - out_r = {en_out, x_out}.
- Reset (asynchronous, any time, including mid-settle):
  - sync flops, cand, cnt, out_r, chg all 0.
  - state = IDLE; busy = 0.
  - No output update completes after reset asserts.
- IDLE:
  - If s2 != out_r: cand <= s2, cnt <= 0, state <= SETTLING.
  - Otherwise hold.
- SETTLING, checked in this priority order:
  - s2 != cand (bounce): cand <= s2, cnt <= 0, stay in SETTLING. Restart has priority over completion.
  - Else if cnt == STABLE_CYCLES-1: out_r <= cand, chg <= (cand != out_r), state <= IDLE.
  - Else: cnt <= cnt+1.
- Bounce back to the old value: the settle completes with cand == out_r, so out_r is unchanged and chg stays 0.
- chg is registered and high for exactly one cycle, on the cycle after out_r updates. It is 0 in all other cycles.
- busy = (state == SETTLING), decoded combinationally from the state register.
- Latency: a clean input change applied before edge 1 appears on x_out/en_out after edge 3+STABLE_CYCLES. chg is high for the following cycle.
- STABLE_CYCLES = 1: output updates on the edge after cand loads, i.e. edge 4.
- cnt never wraps: the maximum value reached is STABLE_CYCLES-1.
- Data bits and enable share one settle window. Any bit changing restarts the whole vector.

Optional Feature:
- Macro: SW_DBNC_GLITCH_CNT_EN.
- Defined:
  - Adds output port glitch_cnt, 8 bits.
  - glitch_cnt increments on every SETTLING restart (s2 != cand while in SETTLING).
  - Saturates at 255; reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sw_dbnc_pkg holds:
  - state enum/localparams ST_IDLE = 1'b0, ST_SETTLING = 1'b1.
  - default constant DBNC_50MHZ_20MS = 1000000.
  - GLITCH_MAX = 8'd255.
- Sub-module sync2 is natural: parameterised-width two-flop synchroniser with asynchronous active-high reset to 0, instantiated once for WIDTH+1 bits.

Test Plan (STABLE_CYCLES = 4 unless stated):
- Reset release, inputs held 0:
  - Outputs stay x_out = 0, en_out = 0, chg = 0, busy = 0 for 20 cycles.
- Clean step sw_in = 8'h40, en_in = 1 before edge 1:
  - busy rises after edge 3.
  - x_out = 8'h40 and en_out = 1 after edge 7.
  - chg = 1 for exactly the cycle after edge 7.
- Bounce: sw_in toggles 8'h01/8'h00 every 2 cycles for 10 cycles, then holds 8'h01:
  - x_out changes only once, 3+4 edges after the final toggle reaches the synchroniser input.
  - Exactly one chg pulse.
  - With SW_DBNC_GLITCH_CNT_EN, glitch_cnt equals the number of restarts.
- Bounce-back: sw_in pulses 8'h00→8'h80→8'h00, held 1 cycle each:
  - busy asserts then clears.
  - x_out stays 0; chg never asserts.
- Reset mid-settle: assert rst two cycles after busy rises:
  - All outputs go to 0 asynchronously, before the next clk edge.
  - After release with sw_in still 8'hFF, the full 3+4-edge latency restarts from scratch.
- STABLE_CYCLES = 1, sw_in = 8'h03:
  - x_out = 8'h03 after edge 4.
- With SW_DBNC_GLITCH_CNT_EN, 300 forced restarts:
  - glitch_cnt = 255, saturated.
